// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants: 640x480@25MHz and 1024x768@65MHz sets,
// plus the helper that sums the four segments of a line or frame.
package vga_timing_pkg;

    // 640x480 @ 60 Hz, 25.175 MHz pixel clock
    localparam int VGA640_H_ACTIVE = 640;
    localparam int VGA640_H_FP     = 16;
    localparam int VGA640_H_SYNC   = 96;
    localparam int VGA640_H_BP     = 48;
    localparam int VGA640_V_ACTIVE = 480;
    localparam int VGA640_V_FP     = 10;
    localparam int VGA640_V_SYNC   = 2;
    localparam int VGA640_V_BP     = 33;
    localparam int VGA640_POL      = 0;

    // 1024x768 @ 60 Hz, 65 MHz pixel clock
    localparam int XGA_H_ACTIVE = 1024;
    localparam int XGA_H_FP     = 24;
    localparam int XGA_H_SYNC   = 136;
    localparam int XGA_H_BP     = 160;
    localparam int XGA_V_ACTIVE = 768;
    localparam int XGA_V_FP     = 3;
    localparam int XGA_V_SYNC   = 6;
    localparam int XGA_V_BP     = 29;
    localparam int XGA_POL      = 0;

    localparam int DEFAULT_CW = 11;

    function automatic int span_total(int act, int fp, int sync, int bp);
        return act + fp + sync + bp;
    endfunction

    localparam int VGA640_H_TOTAL = span_total(VGA640_H_ACTIVE, VGA640_H_FP,
                                               VGA640_H_SYNC, VGA640_H_BP);
    localparam int VGA640_V_TOTAL = span_total(VGA640_V_ACTIVE, VGA640_V_FP,
                                               VGA640_V_SYNC, VGA640_V_BP);
    localparam int XGA_H_TOTAL = span_total(XGA_H_ACTIVE, XGA_H_FP,
                                            XGA_H_SYNC, XGA_H_BP);
    localparam int XGA_V_TOTAL = span_total(XGA_V_ACTIVE, XGA_V_FP,
                                            XGA_V_SYNC, XGA_V_BP);

endpackage

// File: rtl/vga_timing_gen_wrap_counter.sv
// wrap_counter: enabled up-counter that wraps from wrap_val_i to 0.
// Ports: clk_i, rst_i, en_i, wrap_val_i in; count_o, count_d_o, wrap_o out.
// Reset loads wrap_val_i so the first enabled edge lands on 0.
module wrap_counter #(
    parameter int W = 11
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         en_i,
    input  logic [W-1:0] wrap_val_i,
    output logic [W-1:0] count_o,
    output logic [W-1:0] count_d_o,
    output logic         wrap_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    assign wrap_o = en_i && (count_q == wrap_val_i);

    always_comb begin
        count_d = count_q;
        if (en_i) begin
            count_d = (count_q == wrap_val_i) ? '0 : count_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= wrap_val_i;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o   = count_q;
    assign count_d_o = count_d;

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA sync/blanking generator with pixel-rate enable.
// Ports: clock, rst, pix_en in; horiz_sync, vert_sync, video_on,
// pixel_column, pixel_row, line_start, frame_start out; frame_count out
// only when VGA_TIMING_FRAME_CNT_EN is defined (completed-frame counter).
module vga_timing_gen import vga_timing_pkg::*; #(
    parameter int H_ACTIVE = VGA640_H_ACTIVE,
    parameter int H_FP     = VGA640_H_FP,
    parameter int H_SYNC   = VGA640_H_SYNC,
    parameter int H_BP     = VGA640_H_BP,
    parameter int V_ACTIVE = VGA640_V_ACTIVE,
    parameter int V_FP     = VGA640_V_FP,
    parameter int V_SYNC   = VGA640_V_SYNC,
    parameter int V_BP     = VGA640_V_BP,
    parameter int H_POL    = VGA640_POL,
    parameter int V_POL    = VGA640_POL,
    parameter int CW       = DEFAULT_CW
) (
    input  logic          clock,
    input  logic          rst,
    input  logic          pix_en,
    output logic          horiz_sync,
    output logic          vert_sync,
    output logic          video_on,
    output logic [CW-1:0] pixel_column,
    output logic [CW-1:0] pixel_row,
    output logic          line_start,
    output logic          frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
    ,
    output logic [15:0]   frame_count
`endif
);

    localparam int H_TOTAL = span_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = span_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    if (H_TOTAL >= (1 << CW) || V_TOTAL >= (1 << CW) ||
        H_ACTIVE == 0 || H_SYNC == 0 ||
        V_ACTIVE == 0 || V_SYNC == 0) begin : g_bad_params
        $error("vga_timing_gen: illegal timing parameters");
    end

    localparam logic [CW-1:0] H_LAST  = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST  = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT_C = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT_C = CW'(V_ACTIVE);
    localparam logic [CW-1:0] HS_LO   = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_HI   = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CW-1:0] VS_LO   = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_HI   = CW'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic          HP      = (H_POL != 0);
    localparam logic          VP      = (V_POL != 0);

    logic [CW-1:0] h_count, h_next;
    logic [CW-1:0] v_count, v_next;
    logic          h_wrap, v_wrap;

    wrap_counter #(.W(CW)) u_hcnt (
        .clk_i      (clock),
        .rst_i      (rst),
        .en_i       (pix_en),
        .wrap_val_i (H_LAST),
        .count_o    (h_count),
        .count_d_o  (h_next),
        .wrap_o     (h_wrap)
    );

    // Rows step only on the edge where the column wraps.
    wrap_counter #(.W(CW)) u_vcnt (
        .clk_i      (clock),
        .rst_i      (rst),
        .en_i       (h_wrap),
        .wrap_val_i (V_LAST),
        .count_o    (v_count),
        .count_d_o  (v_next),
        .wrap_o     (v_wrap)
    );

    logic video_on_q, video_on_d;
    logic hsync_q, hsync_d;
    logic vsync_q, vsync_d;
    logic line_start_q, frame_start_q;

    // Decode from the counters' next values so the registered flags
    // describe the same (column,row) as the counter registers.
    always_comb begin
        video_on_d = (h_next < H_ACT_C) && (v_next < V_ACT_C);
        hsync_d    = (h_next >= HS_LO && h_next <= HS_HI) ? HP : ~HP;
        vsync_d    = (v_next >= VS_LO && v_next <= VS_HI) ? VP : ~VP;
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            video_on_q    <= 1'b0;
            hsync_q       <= ~HP;
            vsync_q       <= ~VP;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            line_start_q  <= h_wrap;
            frame_start_q <= h_wrap && v_wrap;
            if (pix_en) begin
                video_on_q <= video_on_d;
                hsync_q    <= hsync_d;
                vsync_q    <= vsync_d;
            end
        end
    end

    assign horiz_sync   = hsync_q;
    assign vert_sync    = vsync_q;
    assign video_on     = video_on_q;
    assign pixel_column = h_count;
    assign pixel_row    = v_count;
    assign line_start   = line_start_q;
    assign frame_start  = frame_start_q;

`ifdef VGA_TIMING_FRAME_CNT_EN
    // The first frame_start after reset opens frame 0; later ones
    // each close a frame.
    logic [15:0] frame_cnt_q;
    logic        seen_first_q;

    always_ff @(posedge clock) begin
        if (rst) begin
            frame_cnt_q  <= '0;
            seen_first_q <= 1'b0;
        end else if (frame_start_q) begin
            if (seen_first_q) begin
                frame_cnt_q <= frame_cnt_q + 16'd1;
            end
            seen_first_q <= 1'b1;
        end
    end

    assign frame_count = frame_cnt_q;
`endif

endmodule
